instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end fetch stage that drives the synchronous instruction memory and delivers a stream of (pc, instruction) pairs to decode. It owns the program counter, tracks the one-cycle memory read latency, buffers returned words in a small skid FIFO so decode can stall without losing data, and supports taken-branch and jump redirects with flush.

## Interface
Parameters:
- ADDR_W, 8, instruction word-address width; PC wraps modulo 2^ADDR_W
- DATA_W, 32, instruction width
- DEPTH, 2, skid FIFO entries; legal values are 2 to 4
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  ADDR_W  address to instruction memory; equals fetch_pc register
- imem_instr  in  DATA_W  memory read data; holds word for address sampled at previous edge
- stall  in  1  decode cannot accept this cycle
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_addr  in  ADDR_W  new fetch target
- instr_valid  out  1  FIFO head valid
- instr  out  DATA_W  FIFO head instruction
- instr_pc  out  ADDR_W  address of FIFO head instruction

## Operation
- State: fetch_pc; inflight_valid/inflight_pc (request issued last edge); FIFO of {pc, instr}, count 0..DEPTH.
- Memory model: samples imem_addr every rising edge, data appears on imem_instr after that edge; unissued samples are ignored.
- pop = instr_valid & ~stall.
- issue = ~redirect_valid & (count - pop + inflight_valid < DEPTH); guarantees a slot exists for every in-flight word.
- On issue: inflight_valid<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (ADDR_W wrap, 255->0 at default). No issue: inflight_valid<=0, fetch_pc holds.
- Return: if inflight_valid, push {inflight_pc, imem_instr} into FIFO this edge.
- Simultaneous push and pop: allowed at any count, including full; count is unchanged.
- Redirect (priority over everything except reset): count<=0, inflight_valid<=0, fetch_pc<=redirect_addr, no push, no pop. The returning in-flight word is discarded.
- Redirect while stall=1: still flushes; the stalled head is dropped.
- FIFO never overflows. Push into a full FIFO without a pop is an assertion failure.
- Outputs instr/instr_pc come from the FIFO head register and are stable while stall=1.

## Timing
- Reset values: fetch_pc=RESET_PC, so imem_addr=RESET_PC; inflight_valid=0; count=0; instr_valid=0; instr=0; instr_pc=0 (with FIFO storage cleared).
- Reset asserted mid-stream: at the next edge all state returns to the reset values. Any in-flight word is discarded.
- Startup: edge E1 is the first edge with reset=0 and issues RESET_PC. E2 pushes it, so instr_valid=1 after E2. Throughput is 1 instr/cycle from then on while stall=0.
- Redirect latency: the edge with redirect_valid=1 sets the target. The next edge issues it. instr_valid=1 with instr_pc=redirect_addr after the second edge following the redirect.
- Stall: a held instruction never changes. With stall held, the FIFO fills to DEPTH and issue stops. On release, streaming resumes with no gap, because the buffered entries cover the memory latency.

## Test plan
- Reset, memory preloaded with word i = 0xA000_0000+i -> after E2: instr_valid=1, instr_pc=0, instr=0xA0000000. Following cycles yield pc 1, 2, 3 with no bubbles.
- stall=1 for 5 cycles while streaming at pc 3 -> head stays pc 3, count saturates at DEPTH, imem issue stops. Release -> pcs 3, 4, 5… each exactly once, in order, no gap.
- redirect_valid=1, redirect_addr=0x40, at pc 7 -> pcs 8 and 9 never appear. After 2 edges: instr_pc=0x40, then 0x41.
- Redirect in the same cycle as stall=1 with a full FIFO -> FIFO is flushed, next valid instr_pc equals the redirect target.
- Redirect to 0xFE -> outputs pc 0xFE, 0xFF, then 0x00 (wrap), with data matching those addresses.
- reset=1 for one cycle mid-stream with the FIFO full -> instr_valid=0 the next cycle, imem_addr=RESET_PC, and restart matches the startup timing.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle; master is the fetch unit,
// slave is the memory/decode side. No latency of its own; stall is the decode backpressure.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc,
    input  imem_instr, stall, redirect_valid, redirect_addr
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc,
    output imem_instr, stall, redirect_valid, redirect_addr
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC owner + one-cycle imem latency tracker + skid FIFO; first instr valid two edges after issue.
// Stall holds the FIFO head; issue throttles so every in-flight word always has a free slot.
module instruction_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  instruction_fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight_valid;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_d;
  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];

  logic              head_valid;
  logic              pop_req;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    occupancy;

  assign head_valid = (count != '0);
  assign pop_req    = head_valid & ~bus.stall;
  assign pop        = pop_req & ~bus.redirect_valid;
  assign push       = inflight_valid & ~bus.redirect_valid;

  // Slots committed after this edge: what stays in the FIFO plus the word now returning.
  assign occupancy = {1'b0, count} - (CNT_W + 1)'(pop_req) + (CNT_W + 1)'(inflight_valid);
  assign issue     = ~bus.redirect_valid & (occupancy < (CNT_W + 1)'(DEPTH));

  always_comb begin
    fifo_d  = fifo_q;
    count_d = count;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        fifo_d[i] = fifo_q[i + 1];
      end
      count_d = count - CNT_W'(1);
    end
    if (push && (count_d < CNT_W'(DEPTH))) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(count_d)) begin
          fifo_d[i] = '{pc: inflight_pc, instr: bus.imem_instr};
        end
      end
      count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc       <= ADDR_W'(RESET_PC);
      inflight_pc    <= '0;
      inflight_valid <= 1'b0;
      count          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      // The word returning this edge belongs to the abandoned path and is dropped.
      fetch_pc       <= bus.redirect_addr;
      inflight_valid <= 1'b0;
      count          <= '0;
    end else begin
      fifo_q         <= fifo_d;
      count          <= count_d;
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = fifo_q[0].instr;
  assign bus.instr_pc    = fifo_q[0].pc;

  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CNT_W'(DEPTH))));
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: stimulus queues expected (pc, instr) pairs,
// a negedge monitor pops and compares every time decode consumes the head.
module tb_instruction_fetch_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  instruction_fetch_unit_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  instruction_fetch_unit #(
    .ADDR_W(8), .DATA_W(32), .DEPTH(2), .RESET_PC(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word at address a is 0xA000_0000 + a.
  initial bus.imem_instr = '0;
  always @(posedge clk) bus.imem_instr <= 32'hA000_0000 + {24'h0, bus.imem_addr};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_pc(input logic [7:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc    = pc;
    e.instr = word;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a pop happens at the next edge whenever the head is valid, not stalled,
  // and neither reset nor redirect is flushing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !bus.redirect_valid && bus.instr_valid && !bus.stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %0h instr %0h, required none", bus.instr_pc, bus.instr);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", bus.instr_pc, e.pc);
          check("pop_instr", bus.instr, e.instr);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    tick(2);
    check("rst_imem_addr", bus.imem_addr, 8'h00);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 8'h00);

    // Startup stream 0..7
    expect_pc(8'h00, 32'hA000_0000); expect_pc(8'h01, 32'hA000_0001);
    expect_pc(8'h02, 32'hA000_0002); expect_pc(8'h03, 32'hA000_0003);
    expect_pc(8'h04, 32'hA000_0004); expect_pc(8'h05, 32'hA000_0005);
    expect_pc(8'h06, 32'hA000_0006); expect_pc(8'h07, 32'hA000_0007);
    reset = 1'b0;
    tick(1);
    check("e1_instr_valid", bus.instr_valid, 1'b0);
    check("e1_imem_addr", bus.imem_addr, 8'h01);
    tick(1);
    check("e2_instr_valid", bus.instr_valid, 1'b1);
    check("e2_instr_pc", bus.instr_pc, 8'h00);
    check("e2_instr", bus.instr, 32'hA000_0000);
    tick(3);
    check("pre_stall_pc", bus.instr_pc, 8'h03);

    // Stall 5 cycles: head held, FIFO fills, issue stops at address 5
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("stall_valid", bus.instr_valid, 1'b1);
      check("stall_pc", bus.instr_pc, 8'h03);
      check("stall_instr", bus.instr, 32'hA000_0003);
      check("stall_imem_addr", bus.imem_addr, 8'h05);
    end
    bus.stall = 1'b0;
    tick(5);
    check("pre_redirect_pc", bus.instr_pc, 8'h08);

    // Redirect to 0x40 with pc 8 at the head
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 8'h40;
    tick(1);
    bus.redirect_valid = 1'b0;
    check("redir_flush_valid", bus.instr_valid, 1'b0);
    check("redir_imem_addr", bus.imem_addr, 8'h40);
    expect_pc(8'h40, 32'hA000_0040); expect_pc(8'h41, 32'hA000_0041);
    tick(1);
    check("redir_r1_valid", bus.instr_valid, 1'b0);
    tick(1);
    check("redir_r2_valid", bus.instr_valid, 1'b1);
    check("redir_r2_pc", bus.instr_pc, 8'h40);
    tick(2);

    // Redirect during stall with a full FIFO
    bus.stall = 1'b1;
    tick(2);
    check("full_stall_pc", bus.instr_pc, 8'h42);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 8'h80;
    tick(1);
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    check("stall_redir_valid", bus.instr_valid, 1'b0);
    expect_pc(8'h80, 32'hA000_0080); expect_pc(8'h81, 32'hA000_0081);
    tick(2);
    check("stall_redir_pc", bus.instr_pc, 8'h80);
    tick(2);

    // Redirect near the top of the address space: wrap 0xFF -> 0x00
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 8'hFE;
    tick(1);
    bus.redirect_valid = 1'b0;
    expect_pc(8'hFE, 32'hA000_00FE); expect_pc(8'hFF, 32'hA000_00FF);
    expect_pc(8'h00, 32'hA000_0000); expect_pc(8'h01, 32'hA000_0001);
    tick(2);
    check("wrap_pc", bus.instr_pc, 8'hFE);
    check("wrap_instr", bus.instr, 32'hA000_00FE);
    tick(4);
    check("post_wrap_pc", bus.instr_pc, 8'h02);

    // Mid-stream reset with a full FIFO
    bus.stall = 1'b1;
    tick(2);
    reset = 1'b1;
    bus.stall = 1'b0;
    tick(1);
    check("mid_rst_valid", bus.instr_valid, 1'b0);
    check("mid_rst_imem_addr", bus.imem_addr, 8'h00);
    check("mid_rst_instr_pc", bus.instr_pc, 8'h00);
    reset = 1'b0;
    expect_pc(8'h00, 32'hA000_0000); expect_pc(8'h01, 32'hA000_0001);
    expect_pc(8'h02, 32'hA000_0002);
    tick(1);
    check("restart_e1_valid", bus.instr_valid, 1'b0);
    tick(1);
    check("restart_e2_valid", bus.instr_valid, 1'b1);
    check("restart_e2_pc", bus.instr_pc, 8'h00);
    tick(3);
    bus.stall = 1'b1;
    tick(2);
    check("all_expected_consumed", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
